// File: rtl/ne4_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : ne4_share_sched
// Description : Round-robin scheduler that time-shares one external 4-bit
//               inequality comparator among NREQ requesters. The granted
//               requester's operands are latched at grant and streamed
//               through the comparator one nibble per cycle, LS nibble first.
//               The transaction ends at the first differing nibble or after
//               the last nibble, and a one-cycle DONE strobe is raised.
// Ports       : CLK/RESETN - clock, asynchronous active-low reset
//               REQ, A, B  - per-requester request level and packed operands
//               GNT, BUSY  - one-hot grant, busy (COMPARE or DONE)
//               DONE, DONE_ID, NE - result strobe, requester index, result
//               CMP_I0/CMP_I1/CMP_O - shared comparator interface
// Revision    : 1.0 - initial release
// ============================================================================
module ne4_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic [NREQ-1:0]            REQ,
    input  logic [NREQ*WIDTH-1:0]      A,
    input  logic [NREQ*WIDTH-1:0]      B,
    output logic [NREQ-1:0]            GNT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [$clog2(NREQ)-1:0]    DONE_ID,
    output logic                       NE,
    output logic [3:0]                 CMP_I0,
    output logic [3:0]                 CMP_I1,
    input  logic                       CMP_O
);

    localparam int IW   = $clog2(NREQ);
    localparam int NNIB = WIDTH / 4;
    localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
    localparam logic [IW-1:0] SEL_LAST = IW'(NREQ - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(NNIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               ne_q, ne_d;
    logic [IW-1:0]      done_id_q, done_id_d;

    // Round-robin pick
    logic               found;
    logic [IW-1:0]      pick;
    logic [IW:0]        cand;
    logic [WIDTH-1:0]   a_pick;
    logic [WIDTH-1:0]   b_pick;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;

    // Scan ptr, ptr+1, ... (mod NREQ) and take the first requester found.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (cand == (IW+1)'(j)) && REQ[j]) begin
                    found = 1'b1;
                    pick  = IW'(j);
                end
            end
        end
    end

    // Operand slice of the picked requester.
    always_comb begin
        a_pick = '0;
        b_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                a_pick = A[i*WIDTH +: WIDTH];
                b_pick = B[i*WIDTH +: WIDTH];
            end
        end
    end

    // Nibble k of the latched operands.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NNIB; i++) begin
            if (k_q == KW'(i)) begin
                nib_a = opa_q[4*i +: 4];
                nib_b = opb_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        k_d       = k_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        ne_d      = ne_q;
        done_id_d = done_id_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    opa_d   = a_pick;
                    opb_d   = b_pick;
                    sel_d   = pick;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    k_d     = '0;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (CMP_O) begin
                    // Early termination on first differing nibble.
                    ne_d      = 1'b1;
                    done_id_d = sel_q;
                    state_d   = ST_DONE;
                end else if (k_q == K_LAST) begin
                    ne_d      = 1'b0;
                    done_id_d = sel_q;
                    state_d   = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = (sel_q == SEL_LAST) ? '0 : sel_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            k_q       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            ne_q      <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            k_q       <= k_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            ne_q      <= ne_d;
            done_id_q <= done_id_d;
        end
    end

    assign GNT     = gnt_q;
    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = (state_q == ST_DONE);
    assign DONE_ID = done_id_q;
    assign NE      = ne_q;
    assign CMP_I0  = (state_q == ST_COMPARE) ? nib_a : 4'd0;
    assign CMP_I1  = (state_q == ST_COMPARE) ? nib_b : 4'd0;

endmodule
`default_nettype wire
